// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: forwarding selects and wait-FSM states.
// Pure type definitions; no logic, no latency, no backpressure.
package cpu_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: stage register ids, hazard inputs, stall/flush/forward outputs.
// Wiring only; no latency, no backpressure.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] RS1_D;
    logic [REG_AW-1:0] RS2_D;
    logic [REG_AW-1:0] RS1_E;
    logic [REG_AW-1:0] RS2_E;
    logic [REG_AW-1:0] RD_E;
    logic              ResultSrcE;
    logic              PCSrcE;
    logic [REG_AW-1:0] RD_M;
    logic              RegWriteM;
    logic [REG_AW-1:0] RD_W;
    logic              RegWriteW;
    logic              mc_req_E;
    logic              mc_done;
    logic [1:0]        ForwardA_E;
    logic [1:0]        ForwardB_E;
    logic              StallF;
    logic              StallD;
    logic              StallE;
    logic              FlushD;
    logic              FlushE;
    logic              mc_abort;
    logic              mc_timeout;
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_events;

    modport master (
        output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE, PCSrcE,
               RD_M, RegWriteM, RD_W, RegWriteW, mc_req_E, mc_done,
        input  ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
               mc_abort, mc_timeout, stall_cycles, flush_events
    );

    modport slave (
        input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, ResultSrcE, PCSrcE,
               RD_M, RegWriteM, RD_W, RegWriteW, mc_req_E, mc_done,
        output ForwardA_E, ForwardB_E, StallF, StallD, StallE, FlushD, FlushE,
               mc_abort, mc_timeout, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand bypass selector: picks MEM, then WB, then register file for one execute source.
// Purely combinational, zero latency, no backpressure.
module fwd_select
    import cpu_hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [REG_AW-1:0] i_rd_m,
    input  logic              i_regwrite_m,
    input  logic [REG_AW-1:0] i_rd_w,
    input  logic              i_regwrite_w,
    output fwd_sel_t          o_sel
);

    // x0 is hardwired zero, so a write to it must never be bypassed.
    always_comb begin
        o_sel = FWD_RF;
        if (i_regwrite_m && (i_rd_m != '0) && (i_rd_m == i_rs)) begin
            o_sel = FWD_MEM;
        end else if (i_regwrite_w && (i_rd_w != '0) && (i_rd_w == i_rs)) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: forwarding, load-use/branch stall+flush, multi-cycle wait FSM with timeout abort.
// Stall/flush/forward are combinational (0 cycles); abort/timeout registered; HAZARD_PERF_CNT_EN enables perf counters.
module hazard_ctrl
    import cpu_hazard_pkg::*;
#(
    parameter int MC_MAX_CYCLES = 32,
    parameter int REG_AW        = 5
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hz
);

    localparam int CNT_W = $clog2(MC_MAX_CYCLES + 1);

    hz_state_t        r_state;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_mc_abort;
    logic             r_mc_timeout;

    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;
    logic     w_lw_stall;
    logic     w_mc_busy;
    logic     w_stall_ok;
    logic     w_stall_f;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .i_rs         (hz.RS1_E),
        .i_rd_m       (hz.RD_M),
        .i_regwrite_m (hz.RegWriteM),
        .i_rd_w       (hz.RD_W),
        .i_regwrite_w (hz.RegWriteW),
        .o_sel        (w_fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .i_rs         (hz.RS2_E),
        .i_rd_m       (hz.RD_M),
        .i_regwrite_m (hz.RegWriteM),
        .i_rd_w       (hz.RD_W),
        .i_regwrite_w (hz.RegWriteW),
        .o_sel        (w_fwd_b)
    );

    assign w_lw_stall = hz.ResultSrcE && (hz.RD_E != '0) &&
                        ((hz.RD_E == hz.RS1_D) || (hz.RD_E == hz.RS2_D));
    assign w_mc_busy  = hz.mc_req_E && !hz.mc_done && !r_mc_abort;
    // A taken branch alongside a multi-cycle request is illegal; the branch wins and nothing stalls.
    assign w_stall_ok = !(hz.PCSrcE && hz.mc_req_E);
    assign w_stall_f  = (w_lw_stall || w_mc_busy) && w_stall_ok;

    assign hz.ForwardA_E = w_fwd_a;
    assign hz.ForwardB_E = w_fwd_b;
    assign hz.StallF     = w_stall_f;
    assign hz.StallD     = w_stall_f;
    assign hz.StallE     = w_mc_busy && w_stall_ok;
    assign hz.FlushD     = hz.PCSrcE;
    assign hz.FlushE     = hz.PCSrcE || (w_lw_stall && !w_mc_busy);
    assign hz.mc_abort   = r_mc_abort;
    assign hz.mc_timeout = r_mc_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= RUN;
            r_wait_cnt   <= '0;
            r_mc_abort   <= 1'b0;
            r_mc_timeout <= 1'b0;
        end else begin
            r_mc_abort <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_mc_busy && !hz.PCSrcE) begin
                        r_state    <= MC_WAIT;
                        r_wait_cnt <= CNT_W'(1);
                    end
                end
                MC_WAIT: begin
                    if (hz.mc_done || !hz.mc_req_E) begin
                        r_state <= RUN;
                    end else if (r_wait_cnt == CNT_W'(MC_MAX_CYCLES)) begin
                        // Abort is seen next cycle, which drops mc_busy and releases the stall.
                        r_state      <= RUN;
                        r_mc_abort   <= 1'b1;
                        r_mc_timeout <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_events;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (w_stall_f && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if (hz.PCSrcE && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + 32'd1;
            end
        end
    end

    assign hz.stall_cycles = r_stall_cycles;
    assign hz.flush_events = r_flush_events;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with MC_MAX_CYCLES=4.
module tb_hazard_ctrl;
    import cpu_hazard_pkg::*;

    typedef struct {
        string       nm;
        logic [10:0] ctl;
        logic [63:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [31:0] acc_sc;
    logic [31:0] acc_fe;
    exp_t q[$];

    hazard_ctrl_if #(.REG_AW(5)) bus ();

    hazard_ctrl #(.MC_MAX_CYCLES(4), .REG_AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] act_ctl();
        return {bus.ForwardA_E, bus.ForwardB_E, bus.StallF, bus.StallD, bus.StallE,
                bus.FlushD, bus.FlushE, bus.mc_abort, bus.mc_timeout};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One pipeline cycle: apply inputs just after the edge and queue the expected outputs.
    task automatic st(input string nm,
                      input logic [4:0] rs1d, input logic [4:0] rs2d,
                      input logic [4:0] rs1e, input logic [4:0] rs2e,
                      input logic [4:0] rde, input logic ld, input logic br,
                      input logic [4:0] rdm, input logic rwm,
                      input logic [4:0] rdw, input logic rww,
                      input logic req, input logic done,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic sf, input logic se, input logic fd, input logic fe,
                      input logic ab, input logic to);
        exp_t e;
        @(posedge clk);
        #1;
        bus.RS1_D = rs1d; bus.RS2_D = rs2d; bus.RS1_E = rs1e; bus.RS2_E = rs2e;
        bus.RD_E = rde; bus.ResultSrcE = ld; bus.PCSrcE = br;
        bus.RD_M = rdm; bus.RegWriteM = rwm; bus.RD_W = rdw; bus.RegWriteW = rww;
        bus.mc_req_E = req; bus.mc_done = done;
        e.nm  = nm;
        e.ctl = {fa, fb, sf, sf, se, fd, fe, ab, to};
        e.cnt = {acc_sc, acc_fe};
        q.push_back(e);
`ifdef HAZARD_PERF_CNT_EN
        acc_sc = acc_sc + {31'd0, sf};
        acc_fe = acc_fe + {31'd0, fd};
`endif
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.nm, "_ctl"}, {53'd0, act_ctl()}, {53'd0, e.ctl});
                check({e.nm, "_cnt"}, {bus.stall_cycles, bus.flush_events}, e.cnt);
            end
        end
    end

    initial begin : stim
        n_cmp = 0; n_bad = 0; acc_sc = '0; acc_fe = '0;
        rst = 1'b0;
        bus.RS1_D = '0; bus.RS2_D = '0; bus.RS1_E = '0; bus.RS2_E = '0; bus.RD_E = '0;
        bus.ResultSrcE = 1'b0; bus.PCSrcE = 1'b0; bus.RD_M = '0; bus.RegWriteM = 1'b0;
        bus.RD_W = '0; bus.RegWriteW = 1'b0; bus.mc_req_E = 1'b0; bus.mc_done = 1'b0;
        #3;
        check("reset_ctl", {53'd0, act_ctl()}, 64'd0);
        check("reset_cnt", {bus.stall_cycles, bus.flush_events}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        //        name        rs1d rs2d rs1e rs2e rde ld br rdm rwm rdw rww req dn  fa fb sf se fd fe ab to
        st("fwd_mem",    0,  0,  5,  0,  0, 0, 0,  5, 1,  5, 1, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0);
        st("fwd_wb",     0,  0,  5,  0,  0, 0, 0,  5, 0,  5, 1, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        st("fwd_x0",     0,  0,  0,  0,  0, 0, 0,  0, 1,  0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("fwd_b",      0,  0,  9,  3,  0, 0, 0,  3, 1,  9, 1, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0);
        st("lu_rs2",     0,  7,  0,  0,  7, 1, 0,  0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0);
        st("lu_gone",    0,  7,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("lu_x0",      0,  0,  0,  0,  0, 1, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("lu_rs1",    12,  0,  0,  0, 12, 1, 0,  0, 0,  0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0);
        st("branch",     0,  0,  0,  0,  0, 0, 1,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0);
        st("idle0",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            st($sformatf("mc_wait%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("mc_done",    0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        st("idle1",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("mc_1cyc",    0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        st("idle2",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("cancel_a",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("cancel_b",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("cancel_c",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("after_cnl",  0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("after_dn",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        st("b2b_a",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("b2b_adone",  0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        st("b2b_b",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("b2b_bdone",  0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0);
        st("idle3",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("lu_mc",      4,  0,  0,  0,  4, 1, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("lu_mc_rel",  4,  0,  0,  0,  4, 1, 0,  0, 0,  0, 0, 1, 1,  0, 0, 1, 0, 0, 1, 0, 0);
        st("idle4",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        st("br_mc",      0,  0,  0,  0,  0, 0, 1,  0, 0,  0, 0, 1, 0,  0, 0, 0, 0, 1, 1, 0, 0);
        st("idle5",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 4; i++)
            st($sformatf("to_stall%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("to_abort",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        st("to_rearm",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 1);
        st("to_sticky",  0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);
        st("rst_a",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 1);
        st("rst_b",      0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 1);

        // Asynchronous reset in the middle of an MC_WAIT cycle, checked before any edge.
        #6 rst = 1'b0;
        #1;
        check("async_rst_ctl", {53'd0, act_ctl()}, {53'd0, 11'b00_00_111_00_00});
        check("async_rst_cnt", {bus.stall_cycles, bus.flush_events}, 64'd0);
        acc_sc = '0; acc_fe = '0;
        @(posedge clk);
        #1 rst = 1'b1;

        st("post_rst",   0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 4; i++)
            st($sformatf("to2_stall%0d", i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 0, 1, 1, 0, 0, 0, 0);
        st("to2_abort",  0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1, 1);
        st("to2_end",    0,  0,  0,  0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
